// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and common widths.
// Used by the transmitter and by the baud counter that the receiver also reuses.
package uart_pkg;

  localparam int DEFAULT_CLK_PER_BIT = 868;
  localparam int UART_DATA_BITS      = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLK_PER_BIT-1 and flags the last cycle of each bit.
// Shared between the UART transmitter and receiver.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int                CNT_W   = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || bit_end) cnt_d = '0;
  end

  // NOTE: reset is synchronous and active-low; state flops use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit PHY: one byte per trans_ok strobe, sent LSB first as 8N1/8N2.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop bits.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int STOP_BITS   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [UART_DATA_BITS-1:0] trans_data,
  input  logic                      trans_ok,
  output logic                      trans_busy,
  output logic                      txd
);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_transmitter: STOP_BITS must be 1 or 2");
  end
  if (CLK_PER_BIT < 2) begin : g_bad_clk_per_bit
    $error("uart_transmitter: CLK_PER_BIT must be >= 2");
  end

  localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
  localparam logic       LAST_STOP = (STOP_BITS == 2);

  tx_state_t                 state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic                      stop_cnt_q, stop_cnt_d;
  logic                      txd_q, txd_d;
  logic                      clear;
  logic                      bit_end;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  // Counter restarts on every state change so each bit period starts from zero.
  assign clear      = (state_q == IDLE) || (state_d != state_q);
  assign trans_busy = (state_q != IDLE) || trans_ok;
  assign txd        = txd_q;

  uart_baud_counter #(.CLK_PER_BIT(CLK_PER_BIT)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .bit_end (bit_end)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      IDLE: if (trans_ok) begin
        shift_d    = trans_data;
        bit_idx_d  = '0;
        stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = ^trans_data;
`endif
        state_d    = START;
      end
      START: if (bit_end) begin
        bit_idx_d = '0;
        state_d   = DATA;
      end
      DATA: if (bit_end) begin
        shift_d    = shift_q >> 1;
        bit_idx_d  = bit_idx_q + 3'd1;
        stop_cnt_d = 1'b0;
        if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: if (bit_end) begin
        if (stop_cnt_q == LAST_STOP) state_d = IDLE;
        else                         stop_cnt_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Line level is computed from the next state so txd itself can be a flop.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = parity_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      txd_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule
